// File: rtl/led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// led_mode_sequencer
//
// Cycles two LEDs through four display modes on each debounced press of an
// active-low pushbutton: IDLE (dark), SLOW blink, FAST blink, ALT (the two
// LEDs blink in anti-phase at the slow rate).
//
// Ports
//   clk     in   1  single clock, all state on its rising edge
//   rst_btn in   1  asynchronous active-low reset
//   go_btn  in   1  asynchronous active-low pushbutton (low = pressed)
//   led     out  2  LED drive, registered
//   mode    out  2  current mode (0 IDLE, 1 SLOW, 2 FAST, 3 ALT), registered
// -----------------------------------------------------------------------------
module led_mode_sequencer #(
    parameter int COUNT_WIDTH        = 32,
    parameter int SLOW_MAX_COUNT     = 6000000 - 1,
    parameter int FAST_MAX_COUNT     = 1500000 - 1,
    parameter int DEBOUNCE_MAX_COUNT = 120000 - 1
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       go_btn,
    output logic [1:0] led,
    output logic [1:0] mode
);

    localparam logic [COUNT_WIDTH-1:0] SLOW_MAX_C = COUNT_WIDTH'(SLOW_MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] FAST_MAX_C = COUNT_WIDTH'(FAST_MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] DEB_MAX_C  = COUNT_WIDTH'(DEBOUNCE_MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ONE_C      = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOW = 2'd1,
        ST_FAST = 2'd2,
        ST_ALT  = 2'd3
    } state_t;

    // LED pattern for a given mode and blink phase. ALT enters with led[0]
    // lit (2'b01) and swaps to 2'b10 on the first wrap.
    function automatic logic [1:0] led_pattern(input state_t st, input logic ph);
        logic [1:0] pat;
        case (st)
            ST_IDLE: pat = 2'b00;
            ST_SLOW: pat = {ph, ph};
            ST_FAST: pat = {ph, ph};
            ST_ALT:  pat = {ph, ~ph};
            default: pat = 2'b00;
        endcase
        return pat;
    endfunction

    // Button front end
    logic                   sync1_r;
    logic                   sync2_r;
    logic                   stable_r;
    logic                   stable_d_r;
    logic [COUNT_WIDTH-1:0] deb_cnt_r;
    logic [COUNT_WIDTH-1:0] deb_cnt_next_s;
    logic                   stable_next_s;
    logic                   press_s;

    // Mode / blink state
    state_t                 state_r;
    state_t                 state_next_s;
    logic [COUNT_WIDTH-1:0] blink_cnt_r;
    logic [COUNT_WIDTH-1:0] blink_cnt_next_s;
    logic [COUNT_WIDTH-1:0] max_s;
    logic                   phase_r;
    logic                   phase_next_s;
    logic [1:0]             led_r;
    logic [1:0]             led_next_s;
    logic [1:0]             mode_r;

    // Synchronizer, debounce and edge-history registers
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            stable_r   <= 1'b1;
            stable_d_r <= 1'b1;
            deb_cnt_r  <= '0;
        end else begin
            sync1_r    <= go_btn;
            sync2_r    <= sync1_r;
            stable_r   <= stable_next_s;
            stable_d_r <= stable_r;
            deb_cnt_r  <= deb_cnt_next_s;
        end
    end

    // Debounce: accept a new level only after it has differed for MAX+1 cycles
    always_comb begin
        deb_cnt_next_s = deb_cnt_r;
        stable_next_s  = stable_r;
        if (sync2_r != stable_r) begin
            if (deb_cnt_r == DEB_MAX_C) begin
                stable_next_s  = sync2_r;
                deb_cnt_next_s = '0;
            end else begin
                deb_cnt_next_s = deb_cnt_r + ONE_C;
            end
        end else begin
            deb_cnt_next_s = '0;
        end
    end

    // High for exactly the first cycle the debounced level reads pressed;
    // stable_d_r resets to 1 so a button held through reset cannot fire here.
    assign press_s = stable_d_r & ~stable_r;

    // Mode, blink counter, phase and registered outputs
    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_r     <= ST_IDLE;
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
            led_r       <= 2'b00;
            mode_r      <= 2'b00;
        end else begin
            state_r     <= state_next_s;
            blink_cnt_r <= blink_cnt_next_s;
            phase_r     <= phase_next_s;
            led_r       <= led_next_s;
            mode_r      <= state_next_s;
        end
    end

    // Next mode / counter / phase; a press outranks a same-cycle wrap
    always_comb begin
        state_next_s     = state_r;
        blink_cnt_next_s = blink_cnt_r;
        phase_next_s     = phase_r;
        max_s            = (state_r == ST_FAST) ? FAST_MAX_C : SLOW_MAX_C;

        if (press_s) begin
            case (state_r)
                ST_IDLE: state_next_s = ST_SLOW;
                ST_SLOW: state_next_s = ST_FAST;
                ST_FAST: state_next_s = ST_ALT;
                ST_ALT:  state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
            blink_cnt_next_s = '0;
            phase_next_s     = 1'b0;
        end else if (state_r == ST_IDLE) begin
            blink_cnt_next_s = '0;
            phase_next_s     = 1'b0;
        end else if (blink_cnt_r == max_s) begin
            blink_cnt_next_s = '0;
            phase_next_s     = ~phase_r;
        end else begin
            blink_cnt_next_s = blink_cnt_r + ONE_C;
        end

        // Outputs are decoded from next-state values so they change on the
        // same edge as the mode itself.
        led_next_s = led_pattern(state_next_s, phase_next_s);
    end

    assign led  = led_r;
    assign mode = mode_r;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_mode_sequencer
//
// Directed bench for led_mode_sequencer with SLOW_MAX_COUNT=7,
// FAST_MAX_COUNT=1, DEBOUNCE_MAX_COUNT=3. A behavioural model predicts mode
// from counted presses and led from the number of cycles spent in the current
// mode; a compare process checks both every falling edge, and the stimulus
// adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_led_mode_sequencer;

    localparam int CW      = 8;
    localparam int DEB_LEN = 4;   // cycles a level must persist to be accepted

    logic       clk;
    logic       rst_btn;
    logic       go_btn;
    logic [1:0] led;
    logic [1:0] mode;

    int pass_cnt  = 0;
    int total_cnt = 0;

    led_mode_sequencer #(
        .COUNT_WIDTH       (CW),
        .SLOW_MAX_COUNT    (7),
        .FAST_MAX_COUNT    (1),
        .DEBOUNCE_MAX_COUNT(3)
    ) dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .go_btn (go_btn),
        .led    (led),
        .mode   (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic m_s1, m_s2, m_stable, m_press;
    int   m_run, m_mode, m_age, m_exit_age;

    // Expected LEDs from mode and cycles elapsed since entering it
    function automatic int exp_led(input int md, input int age);
        int half;
        int ph;
        if (md == 0) return 0;
        half = (md == 2) ? 2 : 8;
        ph   = (age / half) % 2;
        if (md == 3) return (ph == 1) ? 2 : 1;
        return (ph == 1) ? 3 : 0;
    endfunction

    always @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            m_s1     <= 1'b1;
            m_s2     <= 1'b1;
            m_stable <= 1'b1;
            m_press  <= 1'b0;
            m_run    <= 0;
            m_mode   <= 0;
            m_age    <= 0;
        end else begin
            m_s1    <= go_btn;
            m_s2    <= m_s1;
            m_press <= 1'b0;
            if (m_s2 != m_stable) begin
                if (m_run + 1 == DEB_LEN) begin
                    m_stable <= m_s2;
                    m_run    <= 0;
                    m_press  <= (m_s2 == 1'b0);
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
            if (m_press) begin
                m_mode     <= (m_mode + 1) % 4;
                m_age      <= 0;
                m_exit_age <= m_age;
            end else if (m_mode != 0) begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("mode_vs_model", int'(mode), m_mode);
        check("led_vs_model", int'(led), exp_led(m_mode, m_age));
    end

    // Wait (bounded) for mode to reach t; n returns falling edges waited
    task automatic wait_mode(input int t, input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            n++;
            if (int'(mode) == t) break;
        end
        check("wait_mode", int'(mode), t);
    endtask

    int n;

    initial begin
        rst_btn = 1'b0;
        go_btn  = 1'b1;
        #1;
        check("reset_mode", int'(mode), 0);
        check("reset_led", int'(led), 0);
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        repeat (3) @(negedge clk);

        // Glitches of 1..3 cycles separated by 2 high cycles: no advance
        for (int w = 1; w <= 3; w++) begin
            go_btn = 1'b0;
            repeat (w) @(negedge clk);
            go_btn = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_mode", int'(mode), 0);

        // Clean press: 2 sync + 4 debounce + 1 pulse cycle
        go_btn = 1'b0;
        wait_mode(1, 12, n);
        check("press_latency", n, 7);
        check("slow_k0", int'(led), 0);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            check("slow_pattern", int'(led), (k < 8) ? 0 : 3);
        end
        repeat (4) @(negedge clk);
        check("held_no_advance", int'(mode), 1);
        go_btn = 1'b1;
        repeat (10) @(negedge clk);
        check("release_no_advance", int'(mode), 1);

        // Collision: press pulse lands in the cycle where the counter is 7
        for (int i = 0; i < 16; i++) begin
            if ((m_age % 8) == 1) break;
            @(negedge clk);
        end
        go_btn = 1'b0;
        wait_mode(2, 12, n);
        check("collision_exit_age", m_exit_age % 8, 7);
        check("collision_led_k0", int'(led), 0);
        @(negedge clk);
        check("fast_k1", int'(led), 0);
        @(negedge clk);
        check("fast_k2", int'(led), 3);
        @(negedge clk);
        check("fast_k3", int'(led), 3);
        @(negedge clk);
        check("fast_k4", int'(led), 0);
        go_btn = 1'b1;
        repeat (10) @(negedge clk);

        // ALT: 01 for 8 cycles then 10
        go_btn = 1'b0;
        wait_mode(3, 12, n);
        check("alt_k0", int'(led), 1);
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            check("alt_pattern", int'(led), (k < 8) ? 1 : 2);
        end
        go_btn = 1'b1;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-ALT, away from any clock edge
        @(posedge clk);
        #3;
        rst_btn = 1'b0;
        #1;
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_led", int'(led), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_mode", int'(mode), 0);
        rst_btn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_mode", int'(mode), 0);
        check("post_rst_led", int'(led), 0);

        // Four presses wrap back to IDLE
        for (int p = 1; p <= 4; p++) begin
            go_btn = 1'b0;
            wait_mode(p % 4, 12, n);
            check("wrap_mode", int'(mode), p % 4);
            go_btn = 1'b1;
            repeat (10) @(negedge clk);
        end
        check("wrap_led", int'(led), 0);

        // Button held through reset: press only after a full debounce
        go_btn  = 1'b0;
        rst_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst_btn = 1'b1;
        repeat (5) @(negedge clk);
        check("held_rst_no_pulse", int'(mode), 0);
        wait_mode(1, 10, n);
        check("held_rst_latency", n, 2);
        go_btn = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
